output_credit_port: RTL and testbench

OUTPUT_CREDIT_PORT -- requirements
Module: output_credit_port

---
 rtl/output_credit_port.sv | 184 ++++++++++++++++++
 tb/tb_output_credit_port.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_credit_port.sv
// output_credit_port: one crossbar output feeding a credit-flow-controlled link.
// Flits are queued in a small FIFO and sent only when the downstream VC named
// by the head flit has a credit. A packet FSM counts body flits to pulse
// packet_sent when the last flit of a packet leaves. A sticky overflow flag
// records any flit dropped because the FIFO was full.

package output_credit_port_pkg;
  localparam int FLIT_VC_W      = 2;
  localparam int FLIT_PAYLOAD_W = 16;

  // Header flits carry the body length (number of flits after the header)
  // in payload[6:0]; body flits carry data.
  typedef struct packed {
    logic [FLIT_VC_W-1:0]      vc;
    logic [FLIT_PAYLOAD_W-1:0] payload;
  } flit_t;
endpackage

module output_credit_port
  import output_credit_port_pkg::*;
#(
  parameter int NUM_VCS    = 2,
  parameter int CREDIT_MAX = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int VC_W      = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CW        = $clog2(CREDIT_MAX + 1),
  localparam int OW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  flit_t                 in_flit,
  input  logic                  in_valid,
  input  logic                  credit_valid,
  input  logic [VC_W-1:0]       credit_vc,
  output flit_t                 link_flit,
  output logic                  link_valid,
  output logic [NUM_VCS-1:0]    buffer_available,
  output logic                  packet_sent,
  output logic                  overflow,
  output logic [0:0]            dbg_state,
  output logic [6:0]            dbg_remaining,
  output logic [OW-1:0]         dbg_occupancy,
  output logic [NUM_VCS*CW-1:0] dbg_credits
);

  // Handshake: in_valid is a push with no back-pressure (a full FIFO with no
  // pop drops the flit and sets overflow); link_valid is a one-cycle
  // transfer with no ready, flow control comes only from returned credits.

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_MAX);
  localparam logic [OW-1:0] OCC_FULL    = OW'(FIFO_DEPTH);

  flit_t           mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [OW-1:0]   occupancy;
  logic [CW-1:0]   credits [NUM_VCS];
  logic [0:0]      state;
  logic [6:0]      remaining;

  flit_t           head;
  logic [VC_W-1:0] head_vc;
  logic            head_vc_ok;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push;

  // FIFO status, head decode and the send (pop) / write (push) decisions.
  always_comb begin
    head       = mem[rd_ptr];
    head_vc    = head.vc[VC_W-1:0];
    head_vc_ok = (int'(head.vc) < NUM_VCS);
    fifo_empty = (occupancy == '0);
    fifo_full  = (occupancy == OCC_FULL);
    pop        = !fifo_empty && head_vc_ok && (credits[head_vc] != '0);
    push       = in_valid && (!fifo_full || pop);
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  // FIFO pointers wrap naturally; occupancy tracks full/empty.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Sticky overflow: a flit arrived to a full FIFO that was not draining.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) overflow <= 1'b0;
    else if (in_valid && fifo_full && !pop) overflow <= 1'b1;
  end

  // Per-VC credit counters: send consumes, return refills, both cancel.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int v = 0; v < NUM_VCS; v++) credits[v] <= CREDIT_FULL;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        case ({pop && (head_vc == VC_W'(v)), credit_valid && (credit_vc == VC_W'(v))})
          2'b10:   if (credits[v] != '0) credits[v] <= credits[v] - CW'(1);
          2'b01:   if (credits[v] != CREDIT_FULL) credits[v] <= credits[v] + CW'(1);
          default: credits[v] <= credits[v];
        endcase
      end
    end
  end

  // Credit availability flags and flattened debug view of the counters.
  always_comb begin
    buffer_available = '0;
    dbg_credits      = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      buffer_available[v]    = (credits[v] != '0);
      dbg_credits[v*CW +: CW] = credits[v];
    end
  end

  // Link register: the popped flit appears on the link one cycle later.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      link_flit  <= '0;
      link_valid <= 1'b0;
    end else begin
      link_valid <= pop;
      link_flit  <= pop ? head : '0;
    end
  end

  // Packet FSM: header loads the body length, body flits count it down;
  // packet_sent is registered so it lines up with the last flit's link_valid.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      packet_sent <= 1'b0;
    end else begin
      packet_sent <= 1'b0;
      if (pop) begin
        case (state)
          ST_IDLE: begin
            remaining <= head.payload[6:0];
            if (head.payload[6:0] == 7'd0) packet_sent <= 1'b1;
            else                           state       <= ST_BODY;
          end
          ST_BODY: begin
            if (remaining == 7'd1) begin
              packet_sent <= 1'b1;
              remaining   <= '0;
              state       <= ST_IDLE;
            end else begin
              remaining <= remaining - 7'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dbg_state     = state;
  assign dbg_remaining = remaining;
  assign dbg_occupancy = occupancy;

endmodule

// File: tb/tb_output_credit_port.sv
// Directed bench for output_credit_port: a vector table for single-packet,
// multi-flit packet and credit-return behaviour, then hand-written sequences
// for credit starvation, overflow, same-cycle send/return and mid-packet reset.

module tb_output_credit_port;
  import output_credit_port_pkg::*;

  logic        clk;
  logic        n_rst;
  flit_t       in_flit;
  logic        in_valid;
  logic        credit_valid;
  logic [0:0]  credit_vc;
  flit_t       link_flit;
  logic        link_valid;
  logic [1:0]  buffer_available;
  logic        packet_sent;
  logic        overflow;
  logic [0:0]  dbg_state;
  logic [6:0]  dbg_remaining;
  logic [2:0]  dbg_occupancy;
  logic [7:0]  dbg_credits;

  int checks;
  int errors;

  output_credit_port #(.NUM_VCS(2), .CREDIT_MAX(8), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .in_flit          (in_flit),
    .in_valid         (in_valid),
    .credit_valid     (credit_valid),
    .credit_vc        (credit_vc),
    .link_flit        (link_flit),
    .link_valid       (link_valid),
    .buffer_available (buffer_available),
    .packet_sent      (packet_sent),
    .overflow         (overflow),
    .dbg_state        (dbg_state),
    .dbg_remaining    (dbg_remaining),
    .dbg_occupancy    (dbg_occupancy),
    .dbg_credits      (dbg_credits)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  ivc;
    logic [15:0] ipl;
    logic        cv;
    logic        cvc;
    logic        lv;
    logic [1:0]  evc;
    logic [15:0] epl;
    logic        ps;
    logic        st;
    logic [1:0]  ba;
    logic [3:0]  c0;
    logic [3:0]  c1;
    logic        ovf;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drivers: inputs are set while at a falling edge, step advances one cycle.
  task automatic drive(input logic iv, input logic [1:0] vc, input logic [15:0] pl,
                       input logic cv, input logic cvc);
    in_valid     = iv;
    in_flit.vc   = vc;
    in_flit.payload = pl;
    credit_valid = cv;
    credit_vc    = cvc;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n, inout int lv_cnt, inout int ps_cnt);
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step();
      lv_cnt += int'(link_valid);
      ps_cnt += int'(packet_sent);
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    step();
    step();
    n_rst = 1'b1;
  endtask

  initial begin
    int lv_cnt;
    int ps_cnt;
    logic [15:0] sent_pl;
    checks = 0;
    errors = 0;
    n_rst  = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);

    //            iv   ivc   ipl      cv   cvc  lv   evc   epl      ps   st   ba     c0    c1    ovf
    tbl[0]  = '{1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'b11, 4'd8, 4'd8, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b1, 1'b0, 2'b11, 4'd7, 4'd8, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'b11, 4'd7, 4'd8, 1'b0};
    tbl[3]  = '{1'b1, 2'd1, 16'h0003, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'b11, 4'd7, 4'd8, 1'b0};
    tbl[4]  = '{1'b1, 2'd1, 16'h0011, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0003, 1'b0, 1'b1, 2'b11, 4'd7, 4'd7, 1'b0};
    tbl[5]  = '{1'b1, 2'd1, 16'h0022, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0011, 1'b0, 1'b1, 2'b11, 4'd7, 4'd6, 1'b0};
    tbl[6]  = '{1'b1, 2'd1, 16'h0033, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0022, 1'b0, 1'b1, 2'b11, 4'd7, 4'd5, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0033, 1'b1, 1'b0, 2'b11, 4'd7, 4'd4, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'b11, 4'd7, 4'd5, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'b11, 4'd8, 4'd5, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'b11, 4'd8, 4'd5, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'b11, 4'd8, 4'd6, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'b11, 4'd8, 4'd7, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'b11, 4'd8, 4'd8, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'b11, 4'd8, 4'd8, 1'b0};

    // Reset state, checked while reset is held
    #12;
    chk("rst_link_valid", 32'(link_valid), 32'd0);
    chk("rst_link_flit", 32'(link_flit), 32'd0);
    chk("rst_packet_sent", 32'(packet_sent), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_buffer_available", 32'(buffer_available), 32'h3);
    chk("rst_credits", 32'(dbg_credits), 32'h88);
    chk("rst_occupancy", 32'(dbg_occupancy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_remaining", 32'(dbg_remaining), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Vector table: single-flit packet, 4-flit packet on vc1, credit returns
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].iv, tbl[i].ivc, tbl[i].ipl, tbl[i].cv, tbl[i].cvc);
      step();
      chk($sformatf("v%0d_link_valid", i), 32'(link_valid), 32'(tbl[i].lv));
      if (tbl[i].lv) begin
        chk($sformatf("v%0d_link_vc", i), 32'(link_flit.vc), 32'(tbl[i].evc));
        chk($sformatf("v%0d_link_payload", i), 32'(link_flit.payload), 32'(tbl[i].epl));
      end
      chk($sformatf("v%0d_packet_sent", i), 32'(packet_sent), 32'(tbl[i].ps));
      chk($sformatf("v%0d_state", i), 32'(dbg_state), 32'(tbl[i].st));
      chk($sformatf("v%0d_buffer_available", i), 32'(buffer_available), 32'(tbl[i].ba));
      chk($sformatf("v%0d_credit0", i), 32'(dbg_credits[3:0]), 32'(tbl[i].c0));
      chk($sformatf("v%0d_credit1", i), 32'(dbg_credits[7:4]), 32'(tbl[i].c1));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(tbl[i].ovf));
    end

    // Drain vc0 credits with 8 single-flit packets
    lv_cnt = 0;
    ps_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'd0, 16'h0000, 1'b0, 1'b0);
      step();
      lv_cnt += int'(link_valid);
      ps_cnt += int'(packet_sent);
    end
    idle_steps(3, lv_cnt, ps_cnt);
    chk("drain_link_count", 32'(lv_cnt), 32'd8);
    chk("drain_packet_count", 32'(ps_cnt), 32'd8);
    chk("drain_credit0", 32'(dbg_credits[3:0]), 32'd0);
    chk("drain_buffer_available", 32'(buffer_available), 32'h2);
    chk("drain_overflow", 32'(overflow), 32'd0);

    // Two more vc0 flits stall without credit
    lv_cnt = 0;
    ps_cnt = 0;
    drive(1'b1, 2'd0, 16'h0040, 1'b0, 1'b0);
    step();
    lv_cnt += int'(link_valid);
    drive(1'b1, 2'd0, 16'h0041, 1'b0, 1'b0);
    step();
    lv_cnt += int'(link_valid);
    idle_steps(4, lv_cnt, ps_cnt);
    chk("stall_link_count", 32'(lv_cnt), 32'd0);
    chk("stall_occupancy", 32'(dbg_occupancy), 32'd2);
    chk("stall_buffer_available", 32'(buffer_available), 32'h2);

    // One credit releases exactly one flit
    lv_cnt = 0;
    sent_pl = 16'hffff;
    drive(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    step();
    lv_cnt += int'(link_valid);
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (link_valid) sent_pl = link_flit.payload;
      lv_cnt += int'(link_valid);
    end
    chk("credit1_link_count", 32'(lv_cnt), 32'd1);
    chk("credit1_payload", 32'(sent_pl), 32'h40);
    chk("credit1_occupancy", 32'(dbg_occupancy), 32'd1);
    chk("credit1_credit0", 32'(dbg_credits[3:0]), 32'd0);

    // Release the last stalled flit so the FIFO is empty with no vc0 credit
    lv_cnt = 0;
    drive(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    step();
    idle_steps(3, lv_cnt, ps_cnt);
    chk("empty_occupancy", 32'(dbg_occupancy), 32'd0);
    chk("empty_credit0", 32'(dbg_credits[3:0]), 32'd0);

    // Five back-to-back flits into an empty FIFO with no credit
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 16'h0050 + 16'(i), 1'b0, 1'b0);
      step();
      if (i == 3) begin
        chk("ovf_fill_occupancy", 32'(dbg_occupancy), 32'd4);
        chk("ovf_fill_overflow", 32'(overflow), 32'd0);
      end
    end
    chk("ovf_occupancy", 32'(dbg_occupancy), 32'd4);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    lv_cnt = 0;
    idle_steps(3, lv_cnt, ps_cnt);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_no_send", 32'(lv_cnt), 32'd0);

    // Credit return on vc0 coinciding with a send on vc0
    drive(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    step();
    chk("same_a_credit0", 32'(dbg_credits[3:0]), 32'd1);
    chk("same_a_link_valid", 32'(link_valid), 32'd0);
    drive(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    step();
    chk("same_b_credit0", 32'(dbg_credits[3:0]), 32'd1);
    chk("same_b_link_valid", 32'(link_valid), 32'd1);
    chk("same_b_payload", 32'(link_flit.payload), 32'h50);
    chk("same_b_occupancy", 32'(dbg_occupancy), 32'd3);
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    step();
    chk("same_c_credit0", 32'(dbg_credits[3:0]), 32'd0);
    chk("same_c_payload", 32'(link_flit.payload), 32'h51);
    chk("same_c_occupancy", 32'(dbg_occupancy), 32'd2);
    step();
    chk("same_d_link_valid", 32'(link_valid), 32'd0);
    chk("same_d_overflow", 32'(overflow), 32'd1);

    // Reset clears the sticky overflow and queued flits
    do_reset();
    chk("rst2_overflow", 32'(overflow), 32'd0);
    chk("rst2_occupancy", 32'(dbg_occupancy), 32'd0);
    chk("rst2_credits", 32'(dbg_credits), 32'h88);

    // Reset in the middle of a packet body
    drive(1'b1, 2'd1, 16'h0005, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'd1, 16'h0061, 1'b0, 1'b0);
    step();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    chk("body_state", 32'(dbg_state), 32'd1);
    chk("body_remaining", 32'(dbg_remaining), 32'd5);
    chk("body_link_valid", 32'(link_valid), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_link_valid", 32'(link_valid), 32'd0);
    chk("mid_rst_link_flit", 32'(link_flit), 32'd0);
    chk("mid_rst_packet_sent", 32'(packet_sent), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    chk("mid_rst_remaining", 32'(dbg_remaining), 32'd0);
    chk("mid_rst_credits", 32'(dbg_credits), 32'h88);
    chk("mid_rst_buffer_available", 32'(buffer_available), 32'h3);
    chk("mid_rst_occupancy", 32'(dbg_occupancy), 32'd0);
    step();
    n_rst = 1'b1;
    lv_cnt = 0;
    ps_cnt = 0;
    idle_steps(4, lv_cnt, ps_cnt);
    chk("post_rst_link_count", 32'(lv_cnt), 32'd0);
    chk("post_rst_packet_count", 32'(ps_cnt), 32'd0);
    chk("post_rst_state", 32'(dbg_state), 32'd0);

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
